// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS-subset control unit.
// Sequences fetch/decode/execute/memory/writeback with timed memory waits.
module mc_ctrl #(
  parameter int EXT_ISA    = 1,
  parameter int WAIT_LIMIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic        i_or_d,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic [1:0]  pc_src,
  output logic        retire,
  output logic        illegal,
  output logic        bus_err,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BREX    = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JEX     = 4'd11,
    S_HALT    = 4'd12
  } state_t;

  localparam bit EXT = (EXT_ISA != 0);
  localparam bit TO_EN = (WAIT_LIMIT > 0);
  localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(WAIT_LIMIT);
  localparam logic [CW-1:0] ONE = CW'(1);

  state_t        st;
  logic [CW-1:0] cnt;

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_instr;

  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign unused_instr = ^instr[25:6];
  assign state = st;

  logic is_lw, is_sw, is_rt, is_beq, is_bne;
  logic is_addi, is_andi, is_ori, is_j;
  logic in_wait, timeout;

  // Opcode classification; extension opcodes only count when enabled.
  always_comb begin
    is_lw   = (op == 6'h23);
    is_sw   = (op == 6'h2B);
    is_rt   = (op == 6'h00) &&
              ((funct == 6'h20) || (funct == 6'h22) ||
               (funct == 6'h24) || (funct == 6'h25) ||
               (funct == 6'h2A));
    is_beq  = (op == 6'h04);
    is_bne  = EXT && (op == 6'h05);
    is_addi = (op == 6'h08);
    is_andi = EXT && (op == 6'h0C);
    is_ori  = EXT && (op == 6'h0D);
    is_j    = (op == 6'h02);
  end

  // A wait state with no completion this cycle may hit the timeout.
  always_comb begin
    in_wait = (st == S_FETCH) || (st == S_MEMRD) ||
              (st == S_MEMWR);
    timeout = TO_EN && in_wait && !mem_ready && (cnt == LIM);
  end

  // State register, wait counter and sticky fault flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= S_FETCH;
      cnt     <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else if (in_wait && !mem_ready) begin
      if (timeout) begin
        st      <= S_HALT;
        bus_err <= 1'b1;
        cnt     <= '0;
      end else begin
        cnt <= cnt + ONE;
      end
    end else begin
      cnt <= '0;
      case (st)
        S_FETCH: st <= S_DECODE;
        S_DECODE: begin
          if (is_lw || is_sw) begin
            st <= S_MEMADR;
          end else if (is_rt) begin
            st <= S_RTYPEEX;
          end else if (is_beq || is_bne) begin
            st <= S_BREX;
          end else if (is_addi || is_andi || is_ori) begin
            st <= S_IMMEX;
          end else if (is_j) begin
            st <= S_JEX;
          end else begin
            st      <= S_HALT;
            illegal <= 1'b1;
          end
        end
        S_MEMADR:  st <= is_lw ? S_MEMRD : S_MEMWR;
        S_MEMRD:   st <= S_MEMWB;
        S_MEMWB:   st <= S_FETCH;
        S_MEMWR:   st <= S_FETCH;
        S_RTYPEEX: st <= S_RTYPEWB;
        S_RTYPEWB: st <= S_FETCH;
        S_BREX:    st <= S_FETCH;
        S_IMMEX:   st <= S_IMMWB;
        S_IMMWB:   st <= S_FETCH;
        S_JEX:     st <= S_FETCH;
        S_HALT:    st <= S_HALT;
        default: begin
          st      <= S_HALT;
          illegal <= 1'b1;
        end
      endcase
    end
  end

  // Datapath controls decoded from the current state; strobes off in reset.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 3'b000;
    pc_src     = 2'b00;
    retire     = 1'b0;
    case (st)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        retire    = mem_ready;
      end
      S_RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
      end
      S_RTYPEWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      S_BREX: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b001;
        pc_src    = 2'b01;
        retire    = 1'b1;
        pc_write  = (is_beq && zero) || (is_bne && !zero);
      end
      S_IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (is_andi) begin
          alu_op = 3'b011;
        end else if (is_ori) begin
          alu_op = 3'b100;
        end else begin
          alu_op = 3'b000;
        end
      end
      S_IMMWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_JEX: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        retire   = 1'b1;
      end
      default: begin
        mem_read = 1'b0;
      end
    endcase
    if (rst) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      retire    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed checks of mc_ctrl.
// Instance a: default parameters; instance b: EXT_ISA=0, WAIT_LIMIT=3.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;

  logic       a_mem_read, a_mem_write, a_i_or_d, a_ir_write;
  logic       a_pc_write, a_reg_write, a_reg_dst, a_mem_to_reg;
  logic       a_alu_src_a, a_retire, a_illegal, a_bus_err;
  logic [1:0] a_alu_src_b, a_pc_src;
  logic [2:0] a_alu_op;
  logic [3:0] a_state;

  logic       b_mem_read, b_mem_write, b_i_or_d, b_ir_write;
  logic       b_pc_write, b_reg_write, b_reg_dst, b_mem_to_reg;
  logic       b_alu_src_a, b_retire, b_illegal, b_bus_err;
  logic [1:0] b_alu_src_b, b_pc_src;
  logic [2:0] b_alu_op;
  logic [3:0] b_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_ctrl dut_a (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero),
    .mem_ready(mem_ready),
    .mem_read(a_mem_read), .mem_write(a_mem_write),
    .i_or_d(a_i_or_d), .ir_write(a_ir_write),
    .pc_write(a_pc_write), .reg_write(a_reg_write),
    .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg),
    .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b),
    .alu_op(a_alu_op), .pc_src(a_pc_src),
    .retire(a_retire), .illegal(a_illegal),
    .bus_err(a_bus_err), .state(a_state)
  );

  mc_ctrl #(.EXT_ISA(0), .WAIT_LIMIT(3)) dut_b (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero),
    .mem_ready(mem_ready),
    .mem_read(b_mem_read), .mem_write(b_mem_write),
    .i_or_d(b_i_or_d), .ir_write(b_ir_write),
    .pc_write(b_pc_write), .reg_write(b_reg_write),
    .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg),
    .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
    .alu_op(b_alu_op), .pc_src(b_pc_src),
    .retire(b_retire), .illegal(b_illegal),
    .bus_err(b_bus_err), .state(b_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if (a_state !== 4'd0) begin
      errors++; $display("FAIL rst_state got %0d exp 0", a_state);
    end
    checks++;
    if ({a_mem_read, a_ir_write, a_pc_write, a_retire} !== 4'b0) begin
      errors++; $display("FAIL rst_strobes got %b exp 0000",
        {a_mem_read, a_ir_write, a_pc_write, a_retire});
    end
    checks++;
    if ({a_illegal, a_bus_err, b_illegal, b_bus_err} !== 4'b0) begin
      errors++; $display("FAIL rst_flags got %b exp 0000",
        {a_illegal, a_bus_err, b_illegal, b_bus_err});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({a_mem_read, a_i_or_d, a_alu_src_b, a_ir_write} !== 5'b10010) begin
      errors++; $display("FAIL rst_first_fetch got %b exp 10010",
        {a_mem_read, a_i_or_d, a_alu_src_b, a_ir_write});
    end
  endtask

  task automatic test_lw();
    logic [3:0] exp_st [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    int rets = 0;
    apply_reset();
    instr = 32'h8C000000;
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (a_state !== exp_st[i]) begin
        errors++; $display("FAIL lw_state[%0d] got %0d exp %0d",
          i, a_state, exp_st[i]);
      end
      if (i == 0) begin
        checks++;
        if ({a_ir_write, a_pc_write} !== 2'b11) begin
          errors++; $display("FAIL lw_fetch_we got %b exp 11",
            {a_ir_write, a_pc_write});
        end
      end
      if (i == 4) begin
        checks++;
        if ({a_reg_write, a_mem_to_reg, a_reg_dst} !== 3'b110) begin
          errors++; $display("FAIL lw_wb got %b exp 110",
            {a_reg_write, a_mem_to_reg, a_reg_dst});
        end
      end
      rets += int'(a_retire);
      tick();
    end
    checks++;
    if (rets !== 1) begin
      errors++; $display("FAIL lw_retire_count got %0d exp 1", rets);
    end
  endtask

  task automatic test_branch();
    apply_reset();
    instr = 32'h14000000;
    zero = 1'b0;
    mem_ready = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if ({a_state, a_pc_write, a_pc_src, a_alu_op, a_retire}
        !== {4'd8, 1'b1, 2'b01, 3'b001, 1'b1}) begin
      errors++; $display("FAIL bne_taken got st=%0d pw=%b ps=%b op=%b rt=%b",
        a_state, a_pc_write, a_pc_src, a_alu_op, a_retire);
    end
    checks++;
    if ({b_state, b_illegal, b_mem_read} !== {4'd12, 1'b1, 1'b0}) begin
      errors++; $display("FAIL bne_noext got st=%0d ill=%b mr=%b exp 12 1 0",
        b_state, b_illegal, b_mem_read);
    end
    zero = 1'b1;
    #1;
    checks++;
    if (a_pc_write !== 1'b0) begin
      errors++; $display("FAIL bne_not_taken got %b exp 0", a_pc_write);
    end
    apply_reset();
    instr = 32'h10000000;
    mem_ready = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if ({a_pc_write, b_state, b_pc_write} !== {1'b1, 4'd8, 1'b1}) begin
      errors++; $display("FAIL beq_taken got %b %0d %b exp 1 8 1",
        a_pc_write, b_state, b_pc_write);
    end
    tick();
    #1;
    checks++;
    if (a_state !== 4'd0) begin
      errors++; $display("FAIL br_return got %0d exp 0", a_state);
    end
    zero = 1'b0;
  endtask

  task automatic test_timeout();
    apply_reset();
    instr = 32'h00000020;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({b_state, b_mem_read} !== {4'd0, 1'b1}) begin
        errors++; $display("FAIL to_wait[%0d] got st=%0d mr=%b exp 0 1",
          i, b_state, b_mem_read);
      end
      tick();
    end
    #1;
    checks++;
    if ({b_state, b_bus_err, b_mem_read} !== {4'd12, 1'b1, 1'b0}) begin
      errors++; $display("FAIL to_halt got st=%0d be=%b mr=%b exp 12 1 0",
        b_state, b_bus_err, b_mem_read);
    end
    checks++;
    if ({a_state, a_bus_err} !== {4'd0, 1'b0}) begin
      errors++; $display("FAIL to_default_early got %0d %b exp 0 0",
        a_state, a_bus_err);
    end
    for (int i = 4; i < 15; i++) tick();
    #1;
    checks++;
    if ({a_state, a_bus_err} !== {4'd0, 1'b0}) begin
      errors++; $display("FAIL to_default_15 got %0d %b exp 0 0",
        a_state, a_bus_err);
    end
    tick();
    #1;
    checks++;
    if ({a_state, a_bus_err} !== {4'd12, 1'b1}) begin
      errors++; $display("FAIL to_default_16 got %0d %b exp 12 1",
        a_state, a_bus_err);
    end
    mem_ready = 1'b1;
    tick();
    #1;
    checks++;
    if ({b_state, b_mem_read, a_state} !== {4'd12, 1'b0, 4'd12}) begin
      errors++; $display("FAIL to_halt_stays got %0d %b %0d exp 12 0 12",
        b_state, b_mem_read, a_state);
    end
  endtask

  task automatic test_sw();
    int wr = 0;
    int rets = 0;
    apply_reset();
    instr = 32'hAC000000;
    mem_ready = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if ({a_state, a_alu_src_a, a_alu_src_b} !== {4'd2, 1'b1, 2'b10}) begin
      errors++; $display("FAIL sw_memadr got %0d %b %b exp 2 1 10",
        a_state, a_alu_src_a, a_alu_src_b);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      mem_ready = (k == 2);
      #1;
      checks++;
      if ({a_state, a_mem_write, a_i_or_d, a_retire}
          !== {4'd5, 1'b1, 1'b1, (k == 2)}) begin
        errors++; $display("FAIL sw_wait[%0d] got st=%0d mw=%b iod=%b rt=%b",
          k, a_state, a_mem_write, a_i_or_d, a_retire);
      end
      wr += int'(a_mem_write);
      rets += int'(a_retire);
      tick();
    end
    #1;
    checks++;
    if ({a_state, b_state} !== {4'd0, 4'd0} || wr !== 3 || rets !== 1) begin
      errors++; $display("FAIL sw_done got st=%0d/%0d wr=%0d rt=%0d exp 0 0 3 1",
        a_state, b_state, wr, rets);
    end
  endtask

  task automatic test_rtype();
    apply_reset();
    instr = 32'h00000020;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    #1;
    checks++;
    if ({a_state, a_alu_src_a, a_alu_src_b, a_alu_op}
        !== {4'd6, 1'b1, 2'b00, 3'b010}) begin
      errors++; $display("FAIL rt_ex got st=%0d a=%b b=%b op=%b",
        a_state, a_alu_src_a, a_alu_src_b, a_alu_op);
    end
    tick();
    #1;
    checks++;
    if ({a_state, a_reg_write, a_reg_dst, a_retire} !== {4'd7, 3'b111}) begin
      errors++; $display("FAIL rt_wb got st=%0d %b%b%b exp 7 111",
        a_state, a_reg_write, a_reg_dst, a_retire);
    end
    tick();
    #1;
    checks++;
    if (a_state !== 4'd0) begin
      errors++; $display("FAIL rt_return got %0d exp 0", a_state);
    end
  endtask

  task automatic test_imm_jump();
    apply_reset();
    instr = 32'h34000000;
    mem_ready = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if ({a_state, a_alu_op, a_alu_src_b} !== {4'd9, 3'b100, 2'b10}) begin
      errors++; $display("FAIL ori_ex got st=%0d op=%b b=%b exp 9 100 10",
        a_state, a_alu_op, a_alu_src_b);
    end
    checks++;
    if ({b_state, b_illegal} !== {4'd12, 1'b1}) begin
      errors++; $display("FAIL ori_noext got %0d %b exp 12 1",
        b_state, b_illegal);
    end
    tick();
    #1;
    checks++;
    if ({a_state, a_reg_write, a_reg_dst, a_mem_to_reg, a_retire}
        !== {4'd10, 4'b1001}) begin
      errors++; $display("FAIL imm_wb got st=%0d %b%b%b%b exp 10 1001",
        a_state, a_reg_write, a_reg_dst, a_mem_to_reg, a_retire);
    end
    apply_reset();
    instr = 32'h30000000;
    mem_ready = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if (a_alu_op !== 3'b011) begin
      errors++; $display("FAIL andi_op got %b exp 011", a_alu_op);
    end
    apply_reset();
    instr = 32'h08000000;
    mem_ready = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if ({a_state, a_pc_src, a_pc_write, a_retire} !== {4'd11, 2'b10, 2'b11}) begin
      errors++; $display("FAIL j_ex got st=%0d ps=%b pw=%b rt=%b",
        a_state, a_pc_src, a_pc_write, a_retire);
    end
    tick();
    #1;
    checks++;
    if (a_state !== 4'd0) begin
      errors++; $display("FAIL j_return got %0d exp 0", a_state);
    end
  endtask

  task automatic test_illegal_funct();
    apply_reset();
    instr = 32'h00000027;
    mem_ready = 1'b1;
    tick();
    #1;
    checks++;
    if ({a_state, a_alu_src_b} !== {4'd1, 2'b11}) begin
      errors++; $display("FAIL dec_out got %0d %b exp 1 11",
        a_state, a_alu_src_b);
    end
    tick();
    #1;
    checks++;
    if ({a_state, a_illegal, a_mem_read} !== {4'd12, 1'b1, 1'b0}) begin
      errors++; $display("FAIL nor_halt got %0d %b %b exp 12 1 0",
        a_state, a_illegal, a_mem_read);
    end
    rst = 1'b1;
    tick();
    #1;
    checks++;
    if ({a_state, a_illegal, a_bus_err, a_mem_read} !== {4'd0, 3'b000}) begin
      errors++; $display("FAIL halt_rst got %0d %b %b %b exp 0 0 0 0",
        a_state, a_illegal, a_bus_err, a_mem_read);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (a_mem_read !== 1'b1) begin
      errors++; $display("FAIL halt_rst_fetch got %b exp 1", a_mem_read);
    end
  endtask

  task automatic test_rst_midread();
    apply_reset();
    instr = 32'h8C000000;
    mem_ready = 1'b1;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    #1;
    checks++;
    if ({a_state, a_mem_read, a_i_or_d} !== {4'd3, 2'b11}) begin
      errors++; $display("FAIL rd_wait got %0d %b %b exp 3 1 1",
        a_state, a_mem_read, a_i_or_d);
    end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({a_mem_read, a_reg_write, a_retire} !== 3'b000) begin
      errors++; $display("FAIL rd_rst_strobes got %b exp 000",
        {a_mem_read, a_reg_write, a_retire});
    end
    tick();
    #1;
    checks++;
    if ({a_state, a_reg_write, a_retire} !== {4'd0, 2'b00}) begin
      errors++; $display("FAIL rd_rst_state got %0d %b %b exp 0 0 0",
        a_state, a_reg_write, a_retire);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({a_state, a_mem_read, a_reg_write} !== {4'd0, 2'b10}) begin
      errors++; $display("FAIL rd_after_rst got %0d %b %b exp 0 1 0",
        a_state, a_mem_read, a_reg_write);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lw();
    test_branch();
    test_timeout();
    test_sw();
    test_rtype();
    test_imm_jump();
    test_illegal_funct();
    test_rst_midread();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
